// File: rtl/pack_fifo.sv
// Byte-packing / unpacking word FIFO between a byte-wide SCSI side and a word-wide memory side.
// MODE 0 packs bytes into words at the tail; MODE 1 unpacks the head word into bytes.
module pack_fifo #(
  parameter int DEPTH    = 8,
  parameter int BYTES    = 4,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int W  = 8 * BYTES,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = $clog2(BYTES)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FLUSH,
  input  logic          MODE,
  input  logic          WR_WORD,
  input  logic [W-1:0]  WR_DATA,
  input  logic          WR_BYTE,
  input  logic [7:0]    WR_BDATA,
  input  logic          COMMIT,
  input  logic          LOAD_BPTR,
  input  logic [BW-1:0] BPTR_INIT,
  input  logic          RD_WORD,
  input  logic          RD_BYTE,
  output logic [W-1:0]  RD_DATA,
  output logic [7:0]    RD_BDATA,
  output logic [AW:0]   COUNT,
  output logic          FULL,
  output logic          EMPTY,
  output logic          ALMOST_FULL,
  output logic [BW-1:0] BPTR,
  output logic          BPTR_EQ0,
  output logic          BPTR_LAST,
  output logic          OVF,
  output logic          UNF
);

  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_CNT    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [BW-1:0] LANE_ONE  = BW'(1);
  localparam logic [BW-1:0] LAST_LANE = '1;

  logic [W-1:0]  mem [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [AW:0]   count, count_n;
  logic [BW-1:0] bptr, bptr_n;
  logic          staged, staged_n;
  logic          ovf, ovf_n, unf, unf_n;

  logic          full, empty, last_lane;
  logic          push, pop, can_push;
  logic          mem_we;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  byte_word;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign last_lane = (bptr == LAST_LANE);

  always_comb begin
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    count_n   = count;
    bptr_n    = bptr;
    staged_n  = staged;
    ovf_n     = ovf;
    unf_n     = unf;
    push      = 1'b0;
    pop       = 1'b0;
    can_push  = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = WR_DATA;

    // A fresh slot starts from zero so unwritten lanes never leak stale data.
    byte_word = staged ? mem[wr_ptr] : '0;
    byte_word[{bptr, 3'b000} +: 8] = WR_BDATA;

    if (FLUSH) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
      bptr_n   = '0;
      staged_n = 1'b0;
      ovf_n    = 1'b0;
      unf_n    = 1'b0;
    end else begin
      if (RD_WORD) begin
        if (empty) unf_n = 1'b1;
        else       pop   = 1'b1;
      end else if (MODE && RD_BYTE && !LOAD_BPTR) begin
        if (empty) begin
          unf_n = 1'b1;
        end else if (last_lane) begin
          pop    = 1'b1;
          bptr_n = '0;
        end else begin
          bptr_n = bptr + LANE_ONE;
        end
      end

      // A same-cycle pop frees the head slot, so a push on FULL is still legal.
      can_push = !full || pop;

      if (LOAD_BPTR) begin
        bptr_n   = BPTR_INIT;
        staged_n = 1'b0;
      end else if (WR_WORD) begin
        if (can_push) begin
          mem_we   = 1'b1;
          push     = 1'b1;
          staged_n = 1'b0;
        end else begin
          ovf_n = 1'b1;
        end
      end else if (!MODE && WR_BYTE) begin
        if (can_push) begin
          mem_we    = 1'b1;
          mem_wdata = byte_word;
          if (last_lane) begin
            push     = 1'b1;
            bptr_n   = '0;
            staged_n = 1'b0;
          end else begin
            bptr_n   = bptr + LANE_ONE;
            staged_n = 1'b1;
          end
        end else begin
          ovf_n = 1'b1;
        end
      end else if (!MODE && COMMIT && staged) begin
        if (can_push) begin
          push     = 1'b1;
          bptr_n   = '0;
          staged_n = 1'b0;
        end else begin
          ovf_n = 1'b1;
        end
      end

      if (push) wr_ptr_n = wr_ptr + PTR_ONE;
      if (pop)  rd_ptr_n = rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count_n = count + CNT_ONE;
        2'b01:   count_n = count - CNT_ONE;
        default: count_n = count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      bptr   <= '0;
      staged <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      bptr   <= bptr_n;
      staged <= staged_n;
      ovf    <= ovf_n;
      unf    <= unf_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[wr_ptr] <= mem_wdata;
  end

  assign RD_DATA     = mem[rd_ptr];
  assign RD_BDATA    = RD_DATA[{bptr, 3'b000} +: 8];
  assign COUNT       = count;
  assign FULL        = full;
  assign EMPTY       = empty;
  assign ALMOST_FULL = (count >= AF_CNT);
  assign BPTR        = bptr;
  assign BPTR_EQ0    = (bptr == '0);
  assign BPTR_LAST   = last_lane;
  assign OVF         = ovf;
  assign UNF         = unf;

endmodule

// File: tb/tb_pack_fifo.sv
// Self-checking bench for pack_fifo: directed vector table, corner-case sequences,
// then randomized traffic against a queue-based reference model.
module tb_pack_fifo;

  localparam int DEPTH = 8;
  localparam int BYTES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush, mode, wr_word, wr_byte, commit, load_bptr, rd_word, rd_byte;
  logic [31:0] wr_data;
  logic [7:0]  wr_bdata;
  logic [1:0]  bptr_init;
  logic [31:0] rd_data;
  logic [7:0]  rd_bdata;
  logic [3:0]  count;
  logic        full, empty, almost_full, bptr_eq0, bptr_last, ovf, unf;
  logic [1:0]  bptr;

  int errors = 0;
  int checks = 0;

  pack_fifo dut (
    .CLK(clk), .RST(rst), .FLUSH(flush), .MODE(mode),
    .WR_WORD(wr_word), .WR_DATA(wr_data), .WR_BYTE(wr_byte), .WR_BDATA(wr_bdata),
    .COMMIT(commit), .LOAD_BPTR(load_bptr), .BPTR_INIT(bptr_init),
    .RD_WORD(rd_word), .RD_BYTE(rd_byte),
    .RD_DATA(rd_data), .RD_BDATA(rd_bdata), .COUNT(count),
    .FULL(full), .EMPTY(empty), .ALMOST_FULL(almost_full),
    .BPTR(bptr), .BPTR_EQ0(bptr_eq0), .BPTR_LAST(bptr_last),
    .OVF(ovf), .UNF(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    flush = 0; mode = 0; wr_word = 0; wr_data = '0; wr_byte = 0; wr_bdata = '0;
    commit = 0; load_bptr = 0; bptr_init = '0; rd_word = 0; rd_byte = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  int          m_bptr;
  logic        m_staged;
  logic [31:0] m_stage;
  logic        m_ovf, m_unf;

  task automatic model_clear();
    mq.delete(); m_bptr = 0; m_staged = 0; m_stage = '0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step();
    bit do_pop, do_push, room;
    logic [31:0] pval;
    int nb;
    do_pop = 0; do_push = 0; pval = '0; nb = m_bptr;
    if (flush) begin
      model_clear();
      return;
    end
    if (rd_word) begin
      if (mq.size() == 0) m_unf = 1; else do_pop = 1;
    end else if (mode && rd_byte && !load_bptr) begin
      if (mq.size() == 0) m_unf = 1;
      else if (m_bptr == BYTES-1) begin do_pop = 1; nb = 0; end
      else nb = m_bptr + 1;
    end
    room = (mq.size() < DEPTH) || do_pop;
    if (load_bptr) begin
      nb = int'(bptr_init); m_staged = 0;
    end else if (wr_word) begin
      if (room) begin do_push = 1; pval = wr_data; m_staged = 0; end
      else m_ovf = 1;
    end else if (!mode && wr_byte) begin
      if (room) begin
        if (!m_staged) m_stage = '0;
        m_stage[8*m_bptr +: 8] = wr_bdata;
        if (m_bptr == BYTES-1) begin do_push = 1; pval = m_stage; nb = 0; m_staged = 0; end
        else begin nb = m_bptr + 1; m_staged = 1; end
      end else m_ovf = 1;
    end else if (!mode && commit && m_staged) begin
      if (room) begin do_push = 1; pval = m_stage; nb = 0; m_staged = 0; end
      else m_ovf = 1;
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(pval);
    m_bptr = nb;
  endtask

  task automatic model_compare();
    int n;
    n = mq.size();
    chk("r_count", 32'(count), 32'(n));
    chk("r_full", 32'(full), 32'(n == DEPTH));
    chk("r_empty", 32'(empty), 32'(n == 0));
    chk("r_afull", 32'(almost_full), 32'(n >= DEPTH-2));
    chk("r_bptr", 32'(bptr), 32'(m_bptr));
    chk("r_bptr_eq0", 32'(bptr_eq0), 32'(m_bptr == 0));
    chk("r_bptr_last", 32'(bptr_last), 32'(m_bptr == BYTES-1));
    chk("r_ovf", 32'(ovf), 32'(m_ovf));
    chk("r_unf", 32'(unf), 32'(m_unf));
    if (n != 0) begin
      chk("r_rd_data", rd_data, mq[0]);
      chk("r_rd_bdata", 32'(rd_bdata), 32'(mq[0][8*m_bptr +: 8]));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef enum logic [3:0] {
    OP_BYTE, OP_LOAD, OP_COMMIT, OP_RDW, OP_RDB0, OP_RDB1, OP_FLUSH, OP_BYTE1
  } op_t;

  typedef struct {
    op_t         op;
    logic [7:0]  bdata;
    logic [1:0]  binit;
    int          e_count;
    int          e_bptr;
    logic        e_ovf;
    logic        e_unf;
    logic        chk_data;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(input op_t op, input logic [7:0] bd, input logic [1:0] bi,
                              input int ec, input int eb, input logic eo, input logic eu,
                              input logic cd, input logic [31:0] ed);
    vec_t v;
    v.op = op; v.bdata = bd; v.binit = bi; v.e_count = ec; v.e_bptr = eb;
    v.e_ovf = eo; v.e_unf = eu; v.chk_data = cd; v.e_data = ed;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    logic [31:0] eq[$];
    logic [7:0]  exp_b[4];
    logic [31:0] w;
    bit fill;
    int f, ld;

    idle();
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_bptr_eq0", 32'(bptr_eq0), 32'd1);
    chk("rst_ovf_unf", {30'd0, ovf, unf}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 0;
    tick();

    //        op         bdata  bi  cnt bptr ovf unf chk data
    vt.push_back(mk(OP_BYTE,   8'h11, 0, 0, 1, 0, 0, 0, 32'h0));
    vt.push_back(mk(OP_BYTE,   8'h22, 0, 0, 2, 0, 0, 0, 32'h0));
    vt.push_back(mk(OP_BYTE,   8'h33, 0, 0, 3, 0, 0, 0, 32'h0));
    vt.push_back(mk(OP_BYTE,   8'h44, 0, 1, 0, 0, 0, 1, 32'h44332211));
    vt.push_back(mk(OP_LOAD,   8'h00, 2, 1, 2, 0, 0, 1, 32'h44332211));
    vt.push_back(mk(OP_BYTE,   8'hAA, 0, 1, 3, 0, 0, 1, 32'h44332211));
    vt.push_back(mk(OP_BYTE,   8'hBB, 0, 2, 0, 0, 0, 1, 32'h44332211));
    vt.push_back(mk(OP_RDW,    8'h00, 0, 1, 0, 0, 0, 1, 32'hBBAA0000));
    vt.push_back(mk(OP_RDW,    8'h00, 0, 0, 0, 0, 0, 0, 32'h0));
    vt.push_back(mk(OP_RDW,    8'h00, 0, 0, 0, 0, 1, 0, 32'h0));
    vt.push_back(mk(OP_BYTE,   8'h55, 0, 0, 1, 0, 1, 0, 32'h0));
    vt.push_back(mk(OP_COMMIT, 8'h00, 0, 1, 0, 0, 1, 1, 32'h00000055));
    vt.push_back(mk(OP_COMMIT, 8'h00, 0, 1, 0, 0, 1, 1, 32'h00000055));
    vt.push_back(mk(OP_FLUSH,  8'h00, 0, 0, 0, 0, 0, 0, 32'h0));
    vt.push_back(mk(OP_BYTE,   8'h66, 0, 0, 1, 0, 0, 0, 32'h0));
    vt.push_back(mk(OP_COMMIT, 8'h00, 0, 1, 0, 0, 0, 1, 32'h00000066));
    vt.push_back(mk(OP_LOAD,   8'h00, 3, 1, 3, 0, 0, 1, 32'h00000066));
    vt.push_back(mk(OP_BYTE,   8'h77, 0, 2, 0, 0, 0, 1, 32'h00000066));
    vt.push_back(mk(OP_RDW,    8'h00, 0, 1, 0, 0, 0, 1, 32'h77000000));
    vt.push_back(mk(OP_RDB0,   8'h00, 0, 1, 0, 0, 0, 1, 32'h77000000));
    vt.push_back(mk(OP_BYTE1,  8'h99, 0, 1, 0, 0, 0, 1, 32'h77000000));
    vt.push_back(mk(OP_RDB1,   8'h00, 0, 1, 1, 0, 0, 1, 32'h77000000));

    foreach (vt[i]) begin
      idle();
      case (vt[i].op)
        OP_BYTE:   begin wr_byte = 1; wr_bdata = vt[i].bdata; end
        OP_BYTE1:  begin mode = 1; wr_byte = 1; wr_bdata = vt[i].bdata; end
        OP_LOAD:   begin load_bptr = 1; bptr_init = vt[i].binit; end
        OP_COMMIT: commit = 1;
        OP_RDW:    rd_word = 1;
        OP_RDB0:   rd_byte = 1;
        OP_RDB1:   begin mode = 1; rd_byte = 1; end
        OP_FLUSH:  flush = 1;
        default:   ;
      endcase
      tick();
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].e_count));
      chk($sformatf("v%0d_bptr", i), 32'(bptr), 32'(vt[i].e_bptr));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vt[i].e_ovf));
      chk($sformatf("v%0d_unf", i), 32'(unf), 32'(vt[i].e_unf));
      if (vt[i].chk_data) chk($sformatf("v%0d_rd_data", i), rd_data, vt[i].e_data);
    end

    // Overflow from empty: 9 pushes, 9th dropped; drain in order.
    idle(); flush = 1; tick(); idle();
    for (int k = 1; k <= 9; k++) begin
      wr_word = 1; wr_data = 32'hC0DE0000 + k;
      tick();
      if (k <= 8) begin
        chk($sformatf("fill%0d_count", k), 32'(count), 32'(k));
        chk($sformatf("fill%0d_afull", k), 32'(almost_full), 32'(k >= 6));
        chk($sformatf("fill%0d_full", k), 32'(full), 32'(k == 8));
        chk($sformatf("fill%0d_ovf", k), 32'(ovf), 32'd0);
      end
    end
    idle();
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(ovf), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d_data", k), rd_data, 32'hC0DE0000 + k);
      rd_word = 1; tick(); idle();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_ovf_sticky", 32'(ovf), 32'd1);

    // FULL with simultaneous push+pop, pointers offset so the ring wraps.
    idle(); flush = 1; tick(); idle();
    for (int k = 0; k < 3; k++) begin wr_word = 1; wr_data = 32'h100 + k; tick(); end
    idle();
    for (int k = 0; k < 3; k++) begin rd_word = 1; tick(); end
    idle();
    eq.delete();
    for (int k = 0; k < 8; k++) begin
      wr_word = 1; wr_data = 32'h200 + k; eq.push_back(wr_data); tick();
    end
    for (int k = 0; k < 5; k++) begin
      wr_word = 1; rd_word = 1; wr_data = 32'h300 + k;
      eq.push_back(wr_data); void'(eq.pop_front());
      tick();
      chk($sformatf("pp%0d_count", k), 32'(count), 32'd8);
      chk($sformatf("pp%0d_ovf", k), 32'(ovf), 32'd0);
      chk($sformatf("pp%0d_full", k), 32'(full), 32'd1);
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("pp_drain%0d", k), rd_data, eq[k]);
      rd_word = 1; tick(); idle();
    end
    chk("pp_empty", 32'(empty), 32'd1);

    // MODE 1 unpacking and underflow.
    idle(); flush = 1; tick(); idle();
    mode = 1; wr_word = 1; wr_data = 32'hDDCCBBAA; tick(); idle(); mode = 1;
    w = 32'hDDCCBBAA;
    for (int k = 0; k < 4; k++) exp_b[k] = w[8*k +: 8];
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("unpack%0d_bdata", k), 32'(rd_bdata), 32'(exp_b[k]));
      rd_byte = 1; tick(); rd_byte = 0;
    end
    chk("unpack_empty", 32'(empty), 32'd1);
    chk("unpack_bptr", 32'(bptr), 32'd0);
    chk("unpack_unf_pre", 32'(unf), 32'd0);
    rd_byte = 1; tick(); idle();
    chk("unpack_unf", 32'(unf), 32'd1);
    chk("unpack_bptr_hold", 32'(bptr), 32'd0);

    // Asynchronous reset in the middle of packing.
    idle(); flush = 1; tick(); idle();
    wr_word = 1; wr_data = 32'h12345678; tick(); idle();
    wr_byte = 1; wr_bdata = 8'h01; tick();
    wr_bdata = 8'h02; tick(); idle();
    chk("pre_rst_bptr", 32'(bptr), 32'd2);
    #2 rst = 1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_bptr", 32'(bptr), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_bptr_eq0", 32'(bptr_eq0), 32'd1);
    #1 rst = 0;
    commit = 1; tick(); idle();
    chk("post_rst_commit_count", 32'(count), 32'd0);
    chk("post_rst_commit_bptr", 32'(bptr), 32'd0);
    wr_byte = 1; wr_bdata = 8'h03; tick(); idle();
    commit = 1; tick(); idle();
    chk("post_rst_slot", rd_data, 32'h00000003);

    // Randomized traffic against the reference model.
    idle(); flush = 1; tick(); idle();
    model_clear();
    fill = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) fill = ~fill;
      idle();
      mode      = ((c / 250) % 2) == 1;
      f         = int'($urandom_range(0, 99) == 0);
      ld        = int'($urandom_range(0, 49) == 0);
      flush     = (f != 0);
      load_bptr = (ld != 0);
      bptr_init = 2'($urandom_range(0, 3));
      wr_word   = ($urandom_range(0, 99) < (fill ? 30 : 8));
      wr_data   = $urandom;
      wr_byte   = ($urandom_range(0, 99) < (fill ? 60 : 20));
      wr_bdata  = 8'($urandom);
      commit    = !wr_byte && ($urandom_range(0, 99) < 8);
      rd_word   = ($urandom_range(0, 99) < (fill ? 8 : 25));
      rd_byte   = !load_bptr && ($urandom_range(0, 99) < (fill ? 15 : 50));
      model_step();
      tick();
      model_compare();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pack_fifo.md
PACK_FIFO -- requirements
Module: pack_fifo

Interface
REQ-001 Parameter DEPTH, 8, number of word slots; power of two, minimum 2.
REQ-002 Parameter BYTES, 4, byte lanes per word; power of two, minimum 2; word width W = 8*BYTES.
REQ-003 Parameter AF_LEVEL, DEPTH-2, COUNT threshold at or above which ALMOST_FULL asserts.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 FLUSH  input  1  synchronous clear of pointers, count and flags; buffer contents are not cleared.
REQ-007 MODE  input  1  0 = byte-in/word-out (SCSI to memory); 1 = word-in/byte-out (memory to SCSI).
REQ-008 WR_WORD  input  1  push WR_DATA as one full word.
REQ-009 WR_DATA  input  W  word write data.
REQ-010 WR_BYTE  input  1  MODE 0 only: write WR_BDATA into lane BPTR of slot at write pointer.
REQ-011 WR_BDATA  input  8  byte write data.
REQ-012 COMMIT  input  1  MODE 0: push a partially packed word.
REQ-013 LOAD_BPTR  input  1  load BPTR from BPTR_INIT (DMA start alignment).
REQ-014 BPTR_INIT  input  log2(BYTES)  starting lane.
REQ-015 RD_WORD  input  1  pop one word.
REQ-016 RD_BYTE  input  1  MODE 1 only: consume lane BPTR of head word.
REQ-017 RD_DATA  output  W  head word, combinational from read pointer.
REQ-018 RD_BDATA  output  8  lane BPTR of head word, combinational.
REQ-019 COUNT  output  log2(DEPTH)+1  words held.
REQ-020 FULL, EMPTY, ALMOST_FULL  output  1 each  COUNT==DEPTH, COUNT==0, COUNT>=AF_LEVEL.
REQ-021 BPTR  output  log2(BYTES)  byte pointer; BPTR_EQ0 / BPTR_LAST (1 bit each) flag lane 0 / lane BYTES-1.
REQ-022 OVF, UNF  output  1 each  sticky overflow / underflow error flags.

Function
REQ-023 Write and read pointers SHALL be log2(DEPTH) bits, incrementing by 1 and wrapping DEPTH-1 -> 0 without a bubble.
REQ-024 WR_WORD when not FULL SHALL store WR_DATA at write pointer, advance it, and COUNT+1; when FULL and RD_WORD is not popping that cycle, the push SHALL be dropped and OVF set.
REQ-025 RD_WORD when not EMPTY SHALL advance read pointer and COUNT-1; when EMPTY it SHALL be ignored and UNF set.
REQ-026 Simultaneous valid push and pop SHALL leave COUNT unchanged; push on FULL with a same-cycle pop SHALL be accepted.
REQ-027 MODE 0 byte write when not FULL: lane BPTR of slot[write pointer] <= WR_BDATA, BPTR+1; the first byte after reset, FLUSH, LOAD_BPTR or a push SHALL clear all other lanes of that slot to 0 in the same cycle.
REQ-028 MODE 0 byte write with BPTR==BYTES-1 SHALL push the slot (pointer+1, COUNT+1) and wrap BPTR to 0 in that cycle.
REQ-029 MODE 0 byte write when FULL SHALL be dropped and set OVF; BPTR unchanged.
REQ-030 COMMIT with at least one byte staged and not FULL SHALL push the slot and reset BPTR to 0; with nothing staged it SHALL be a no-op.
REQ-031 MODE 1 RD_BYTE when not EMPTY SHALL advance BPTR; at BPTR==BYTES-1 it SHALL pop the head word and wrap BPTR to 0; when EMPTY, ignored and UNF set.
REQ-032 Priority per cycle: FLUSH > LOAD_BPTR > WR_WORD > WR_BYTE/COMMIT; RD_WORD > RD_BYTE; WR_BYTE in MODE 1 and RD_BYTE in MODE 0 SHALL be ignored.
REQ-033 LOAD_BPTR SHALL set BPTR = BPTR_INIT and discard any partially staged bytes without pushing.
REQ-034 OVF/UNF SHALL stay set until RST or FLUSH.
REQ-035 Status outputs SHALL be registered-state decodes (no combinational path from request inputs).

Reset
REQ-036 RST assertion SHALL immediately force pointers, BPTR, COUNT, OVF, UNF to 0 (EMPTY=1, FULL=0, ALMOST_FULL=0, BPTR_EQ0=1) regardless of CLK; buffer contents unspecified.
REQ-037 Reset mid-packing SHALL discard staged bytes; first post-reset byte starts a clean slot.

Verification
REQ-038 DEPTH=8,BYTES=4, MODE 0: bytes 11,22,33,44 -> COUNT=1, RD_DATA=32'h44332211, BPTR=0.
REQ-039 LOAD_BPTR with BPTR_INIT=2, bytes AA,BB -> push after BB, RD_DATA=32'hBBAA0000.
REQ-040 9 WR_WORDs from empty -> COUNT=8, FULL=1, OVF=1, 9th word absent; pop 8 returns words 1..8 in order, EMPTY=1.
REQ-041 FULL with simultaneous WR_WORD+RD_WORD -> COUNT stays 8, OVF=0, order preserved across pointer wrap.
REQ-042 MODE 1: push 32'hDDCCBBAA, 4x RD_BYTE -> RD_BDATA AA,BB,CC,DD, EMPTY=1 after 4th; 5th RD_BYTE sets UNF.
REQ-043 Bytes 01,02 then async RST mid-cycle -> COUNT=0, BPTR=0 immediately; COMMIT afterwards is a no-op.
